// File: rtl/rx_ipv4_parser.sv
// rx_ipv4_parser: validates IPv4 headers coming out of rx_ethernet and forwards the
// padding-trimmed UDP/TCP payload as a strobed byte stream with header metadata.
module rx_ipv4_parser #(
  parameter int         OCT          = 8,
  parameter logic [7:0] PROTO_UDP    = 8'd17,
  parameter logic [7:0] PROTO_TCP    = 8'd6,
  parameter bit         ACCEPT_BCAST = 1'b1
) (
  input  logic           RX_CLK,
  input  logic           rst,
  input  logic [31:0]    ip_addr,
  input  logic           rx_payload_ip,
  input  logic [OCT-1:0] rx_payload,
  output logic [OCT-1:0] rx_data,
  output logic           rx_data_udp,
  output logic           rx_data_tcp,
  output logic           rx_hdr_valid,
  output logic [31:0]    rx_src_ip,
  output logic [7:0]     rx_proto,
  output logic [15:0]    rx_len,
  output logic           rx_end,
  output logic           rx_ip_err
);

  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DROP} state_t;

  state_t      state, state_next;
  logic [5:0]  k;
  logic [5:0]  hdr_len;
  logic [15:0] csum;
  logic [7:0]  csum_hi;
  logic [15:0] tot_len;
  logic        mf;
  logic [12:0] frag_off;
  logic [7:0]  proto;
  logic [31:0] src_ip;
  logic [31:0] dst_ip;
  logic [15:0] pay_cnt;

  logic [7:0]  b;
  logic [16:0] sum_raw;
  logic [15:0] csum_add;
  logic [15:0] pay_len;
  logic [31:0] dst_now;
  logic        early_err, hdr_last, hdr_bad, hdr_keep;
  logic        accept, err_pulse, end_pulse, strobe;

  assign b         = rx_payload[7:0];
  assign early_err = (b[7:4] != 4'd4) || (b[3:0] < 4'd5);
  assign hdr_last  = (k == hdr_len - 6'd1);

  // Ones'-complement add of the current 16-bit word with end-around carry.
  assign sum_raw  = {1'b0, csum} + {1'b0, csum_hi, b};
  assign csum_add = sum_raw[15:0] + {15'd0, sum_raw[16]};

  // With IHL=5 the last destination byte is the decision byte itself.
  assign dst_now  = (k == 6'd19) ? {dst_ip[23:0], b} : dst_ip;
  assign pay_len  = tot_len - {10'd0, hdr_len};

  assign hdr_bad  = (csum_add != 16'hFFFF) || (tot_len < {10'd0, hdr_len}) ||
                    mf || (frag_off != 13'd0);
  assign hdr_keep = ((dst_now == ip_addr) || (ACCEPT_BCAST && (dst_now == 32'hFFFF_FFFF))) &&
                    ((proto == PROTO_UDP) || (proto == PROTO_TCP));

  // NOTE: state is sequential, so it uses non-blocking (<=) to avoid races
  // between flops sampled on the same edge.
  always_ff @(posedge RX_CLK or negedge rst) begin
    if (!rst) state <= DROP;
    else      state <= state_next;
  end

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    err_pulse  = 1'b0;
    end_pulse  = 1'b0;
    strobe     = 1'b0;
    case (state)
      IDLE: begin
        if (rx_payload_ip) begin
          if (early_err) begin
            err_pulse  = 1'b1;
            state_next = DROP;
          end else begin
            state_next = HDR;
          end
        end
      end
      HDR: begin
        if (!rx_payload_ip) begin
          err_pulse  = 1'b1;
          state_next = IDLE;
        end else if (hdr_last) begin
          state_next = DROP;
          if (hdr_bad) begin
            err_pulse = 1'b1;
          end else if (hdr_keep) begin
            accept = 1'b1;
            if (pay_len == 16'd0) end_pulse  = 1'b1;
            else                  state_next = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (!rx_payload_ip) begin
          err_pulse  = 1'b1;
          state_next = IDLE;
        end else begin
          strobe = 1'b1;
          if (pay_cnt == rx_len - 16'd1) begin
            end_pulse  = 1'b1;
            state_next = DROP;
          end
        end
      end
      DROP: begin
        if (!rx_payload_ip) state_next = IDLE;
      end
      default: state_next = DROP;
    endcase
  end

  always_ff @(posedge RX_CLK or negedge rst) begin
    if (!rst) begin
      rx_data      <= '0;
      rx_data_udp  <= 1'b0;
      rx_data_tcp  <= 1'b0;
      rx_hdr_valid <= 1'b0;
      rx_src_ip    <= '0;
      rx_proto     <= '0;
      rx_len       <= '0;
      rx_end       <= 1'b0;
      rx_ip_err    <= 1'b0;
      k            <= '0;
      hdr_len      <= '0;
      csum         <= '0;
      csum_hi      <= '0;
      tot_len      <= '0;
      mf           <= 1'b0;
      frag_off     <= '0;
      proto        <= '0;
      src_ip       <= '0;
      dst_ip       <= '0;
      pay_cnt      <= '0;
    end else begin
      rx_hdr_valid <= accept;
      rx_ip_err    <= err_pulse;
      rx_end       <= end_pulse;
      rx_data_udp  <= strobe && (rx_proto == PROTO_UDP);
      rx_data_tcp  <= strobe && (rx_proto == PROTO_TCP);

      if (strobe) begin
        rx_data <= rx_payload;
        pay_cnt <= pay_cnt + 16'd1;
      end

      if (accept) begin
        rx_src_ip <= src_ip;
        rx_proto  <= proto;
        rx_len    <= pay_len;
        pay_cnt   <= '0;
      end

      if (state == IDLE && rx_payload_ip) begin
        k       <= 6'd1;
        hdr_len <= {b[3:0], 2'b00};
        csum    <= '0;
        csum_hi <= b;
      end

      if (state == HDR) begin
        k <= k + 6'd1;
        if (!k[0]) csum_hi <= b;
        else       csum    <= csum_add;
        case (k)
          6'd2:  tot_len[15:8] <= b;
          6'd3:  tot_len[7:0]  <= b;
          6'd6: begin
            mf             <= b[5];
            frag_off[12:8] <= b[4:0];
          end
          6'd7:  frag_off[7:0] <= b;
          6'd9:  proto         <= b;
          6'd12, 6'd13, 6'd14, 6'd15: src_ip <= {src_ip[23:0], b};
          6'd16, 6'd17, 6'd18, 6'd19: dst_ip <= {dst_ip[23:0], b};
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx_ipv4_parser.sv
// tb_rx_ipv4_parser: directed and randomized IPv4 frames checked cycle by cycle
// against a frame-level reference model of the parser.
module tb_rx_ipv4_parser;

  localparam logic [31:0] LOCAL_IP = 32'hC0A8_010A;
  localparam logic [4:0]  C_HDR = 5'b10000;
  localparam logic [4:0]  C_ERR = 5'b01000;
  localparam logic [4:0]  C_END = 5'b00100;
  localparam logic [4:0]  C_UDP = 5'b00010;
  localparam logic [4:0]  C_TCP = 5'b00001;

  logic        RX_CLK = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ip_addr = LOCAL_IP;
  logic        rx_payload_ip = 1'b0;
  logic [7:0]  rx_payload = 8'd0;
  logic [7:0]  rx_data;
  logic        rx_data_udp, rx_data_tcp, rx_hdr_valid, rx_end, rx_ip_err;
  logic [31:0] rx_src_ip;
  logic [7:0]  rx_proto;
  logic [15:0] rx_len;

  rx_ipv4_parser #(
    .OCT(8), .PROTO_UDP(8'd17), .PROTO_TCP(8'd6), .ACCEPT_BCAST(1'b1)
  ) dut (
    .RX_CLK(RX_CLK), .rst(rst), .ip_addr(ip_addr),
    .rx_payload_ip(rx_payload_ip), .rx_payload(rx_payload),
    .rx_data(rx_data), .rx_data_udp(rx_data_udp), .rx_data_tcp(rx_data_tcp),
    .rx_hdr_valid(rx_hdr_valid), .rx_src_ip(rx_src_ip), .rx_proto(rx_proto),
    .rx_len(rx_len), .rx_end(rx_end), .rx_ip_err(rx_ip_err)
  );

  always #5 RX_CLK = ~RX_CLK;

  int n_pass = 0;
  int n_total = 0;

  logic [7:0]  frm[$];
  logic [4:0]  exp_ctl[0:255];
  logic [7:0]  exp_data[0:255];
  logic [4:0]  obs_ctl[0:255];
  logic [7:0]  obs_data[0:255];
  logic [31:0] obs_src[0:255];
  logic [7:0]  obs_proto[0:255];
  logic [15:0] obs_len[0:255];
  logic [31:0] exp_src;
  logic [7:0]  exp_proto;
  logic [15:0] exp_len;
  int          exp_hdr_cyc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    assert (got === want) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, want);
  endtask

  // Rewrites the header checksum field so that the header sums to 0xFFFF.
  task automatic fix_csum();
    int          h;
    int unsigned s;
    logic [15:0] c;
    h = 4 * int'(frm[0][3:0]);
    s = 0;
    frm[10] = 8'd0;
    frm[11] = 8'd0;
    for (int i = 0; i < h; i += 2) s += {16'd0, frm[i], frm[i+1]};
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
    c = ~s[15:0];
    frm[10] = c[15:8];
    frm[11] = c[7:0];
  endtask

  task automatic build(input int ihl, input int plen, input int pad, input logic [7:0] proto,
                       input logic [31:0] dst, input logic [15:0] flags);
    logic [15:0] tl;
    logic [31:0] src;
    tl  = 16'(4 * ihl + plen);
    src = $urandom;
    frm.delete();
    frm.push_back({4'd4, 4'(ihl)});
    frm.push_back(8'($urandom));
    frm.push_back(tl[15:8]);
    frm.push_back(tl[7:0]);
    frm.push_back(8'($urandom));
    frm.push_back(8'($urandom));
    frm.push_back(flags[15:8]);
    frm.push_back(flags[7:0]);
    frm.push_back(8'($urandom_range(1, 255)));
    frm.push_back(proto);
    frm.push_back(8'd0);
    frm.push_back(8'd0);
    for (int i = 3; i >= 0; i--) frm.push_back(src[8*i +: 8]);
    for (int i = 3; i >= 0; i--) frm.push_back(dst[8*i +: 8]);
    for (int i = 20; i < 4 * ihl; i++) frm.push_back(8'($urandom));
    fix_csum();
    for (int i = 0; i < plen + pad; i++) frm.push_back(8'($urandom));
  endtask

  // Expected per-cycle outputs for a frame of n bytes starting at cycle 0.
  task automatic model(input int n);
    int          h, tl, plen;
    int unsigned s;
    logic [31:0] dst;
    logic [7:0]  pr;
    bit          frag;
    for (int c = 0; c < 256; c++) begin
      exp_ctl[c]  = 5'd0;
      exp_data[c] = 8'd0;
    end
    exp_hdr_cyc = -1;
    if (frm[0][7:4] != 4'd4 || frm[0][3:0] < 4'd5) begin
      exp_ctl[1] = C_ERR;
      return;
    end
    h = 4 * int'(frm[0][3:0]);
    if (n < h) begin
      exp_ctl[n+1] = C_ERR;
      return;
    end
    s = 0;
    for (int i = 0; i < h; i += 2) s += {16'd0, frm[i], frm[i+1]};
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
    tl   = int'({frm[2], frm[3]});
    frag = frm[6][5] || ({frm[6][4:0], frm[7]} != 13'd0);
    pr   = frm[9];
    dst  = {frm[16], frm[17], frm[18], frm[19]};
    if (s != 32'hFFFF || tl < h || frag) begin
      exp_ctl[h] = C_ERR;
      return;
    end
    if (!(dst == LOCAL_IP || dst == 32'hFFFF_FFFF) || !(pr == 8'd17 || pr == 8'd6)) return;
    plen        = tl - h;
    exp_hdr_cyc = h;
    exp_ctl[h]  = C_HDR;
    exp_src     = {frm[12], frm[13], frm[14], frm[15]};
    exp_proto   = pr;
    exp_len     = 16'(plen);
    if (plen == 0) begin
      exp_ctl[h] |= C_END;
      return;
    end
    for (int j = 0; j < plen && h + j < n; j++) begin
      exp_ctl[h+j+1] |= (pr == 8'd17) ? C_UDP : C_TCP;
      exp_data[h+j+1] = frm[h+j];
    end
    if (n - h >= plen) exp_ctl[h+plen] |= C_END;
    else               exp_ctl[n+1]    |= C_ERR;
  endtask

  task automatic sample(input int i);
    obs_ctl[i]   = {rx_hdr_valid, rx_ip_err, rx_end, rx_data_udp, rx_data_tcp};
    obs_data[i]  = rx_data;
    obs_src[i]   = rx_src_ip;
    obs_proto[i] = rx_proto;
    obs_len[i]   = rx_len;
  endtask

  task automatic compare(input string tag, input int lo, input int hi);
    for (int c = lo; c <= hi; c++) begin
      check($sformatf("%s ctl@%0d", tag, c), 64'(obs_ctl[c]), 64'(exp_ctl[c]));
      if (exp_ctl[c][1:0] != 2'b00)
        check($sformatf("%s data@%0d", tag, c), 64'(obs_data[c]), 64'(exp_data[c]));
      if (c == exp_hdr_cyc || (c == hi && exp_hdr_cyc >= 0 && exp_hdr_cyc < hi)) begin
        check($sformatf("%s src@%0d", tag, c), 64'(obs_src[c]), 64'(exp_src));
        check($sformatf("%s proto@%0d", tag, c), 64'(obs_proto[c]), 64'(exp_proto));
        check($sformatf("%s len@%0d", tag, c), 64'(obs_len[c]), 64'(exp_len));
      end
    end
  endtask

  task automatic run_frame(input string tag);
    int n;
    n = frm.size();
    model(n);
    for (int c = 0; c < n + 4; c++) begin
      rx_payload_ip = (c < n);
      rx_payload    = (c < n) ? frm[c] : 8'($urandom);
      @(posedge RX_CLK);
      #1;
      sample(c + 1);
    end
    compare(tag, 1, n + 4);
  endtask

  initial begin
    int          n, ihl, plen, pad, cut;
    logic [7:0]  pr;
    logic [31:0] dst;
    logic [15:0] flags;

    #1 rst = 1'b0;
    repeat (3) @(posedge RX_CLK);
    #1;
    check("reset_ctl", 64'({rx_hdr_valid, rx_ip_err, rx_end, rx_data_udp, rx_data_tcp,
                            rx_data, rx_len}), 64'd0);
    check("reset_meta", 64'({rx_src_ip, rx_proto}), 64'd0);
    rst = 1'b1;
    repeat (2) @(posedge RX_CLK);
    #1;

    build(5, 16, 10, 8'd17, LOCAL_IP, 16'h0000);
    run_frame("udp");
    check("udp hdr_t20", 64'(obs_ctl[20]), 64'(C_HDR));
    check("udp len", 64'(obs_len[20]), 64'd16);
    check("udp proto", 64'(obs_proto[20]), 64'd17);
    check("udp end_t36", 64'(obs_ctl[36]), 64'(C_END | C_UDP));

    build(5, 16, 10, 8'd17, LOCAL_IP, 16'h0000);
    frm[8] ^= 8'h01;
    run_frame("bad_csum");
    check("bad_csum err_t20", 64'(obs_ctl[20]), 64'(C_ERR));

    build(6, 8, 4, 8'd6, LOCAL_IP, 16'h0000);
    run_frame("tcp_opt");
    check("tcp_opt hdr_t24", 64'(obs_ctl[24]), 64'(C_HDR));
    check("tcp_opt len", 64'(obs_len[24]), 64'd8);

    build(5, 16, 10, 8'd17, 32'hC0A8_010B, 16'h0000);
    run_frame("addr_miss");
    build(5, 16, 10, 8'd17, 32'hFFFF_FFFF, 16'h0000);
    run_frame("bcast");
    build(5, 8, 0, 8'd1, LOCAL_IP, 16'h0000);
    run_frame("icmp_drop");

    build(5, 16, 0, 8'd17, LOCAL_IP, 16'h0000);
    while (frm.size() > 30) void'(frm.pop_back());
    run_frame("trunc_pay");
    check("trunc_pay err_t31", 64'(obs_ctl[31]), 64'(C_ERR));

    build(5, 16, 4, 8'd17, LOCAL_IP, 16'h2000);
    run_frame("frag_mf");
    build(5, 16, 4, 8'd17, LOCAL_IP, 16'h0010);
    run_frame("frag_off");
    build(5, 16, 4, 8'd17, LOCAL_IP, 16'h4000);
    run_frame("df_ok");

    build(5, 16, 4, 8'd17, LOCAL_IP, 16'h0000);
    frm[0] = 8'h65;
    run_frame("ver6");
    check("ver6 err_t1", 64'(obs_ctl[1]), 64'(C_ERR));
    build(5, 16, 4, 8'd17, LOCAL_IP, 16'h0000);
    frm[0] = 8'h44;
    run_frame("ihl4");

    build(5, 0, 8, 8'd17, LOCAL_IP, 16'h0000);
    frm[2] = 8'd0;
    frm[3] = 8'd16;
    fix_csum();
    run_frame("tl_short");
    build(5, 0, 6, 8'd17, LOCAL_IP, 16'h0000);
    run_frame("zero_len");
    check("zero_len hdr_end", 64'(obs_ctl[20]), 64'(C_HDR | C_END));
    build(5, 16, 0, 8'd17, LOCAL_IP, 16'h0000);
    while (frm.size() > 12) void'(frm.pop_back());
    run_frame("trunc_hdr");
    build(5, 5, 0, 8'd6, LOCAL_IP, 16'h0000);
    run_frame("no_pad");

    // Reset asserted during payload byte 5, released while the frame continues.
    build(5, 16, 10, 8'd17, LOCAL_IP, 16'h0000);
    n = frm.size();
    model(n);
    for (int c = 0; c < n + 4; c++) begin
      if (c == 27) rst = 1'b1;
      rx_payload_ip = (c < n);
      rx_payload    = (c < n) ? frm[c] : 8'($urandom);
      if (c == 25) begin
        #2 rst = 1'b0;
        #1;
        check("rst_async_ctl", 64'({rx_hdr_valid, rx_ip_err, rx_end, rx_data_udp,
                                    rx_data_tcp, rx_data, rx_len}), 64'd0);
        check("rst_async_meta", 64'({rx_src_ip, rx_proto}), 64'd0);
      end
      @(posedge RX_CLK);
      #1;
      sample(c + 1);
    end
    compare("rst_pre", 1, 25);
    for (int c = 26; c <= n + 4; c++) begin
      check($sformatf("rst_after ctl@%0d", c),
            64'({obs_ctl[c], obs_data[c], obs_len[c]}), 64'd0);
      check($sformatf("rst_after meta@%0d", c), 64'({obs_src[c], obs_proto[c]}), 64'd0);
    end

    build(5, 16, 10, 8'd17, LOCAL_IP, 16'h0000);
    run_frame("post_rst");

    for (int r = 0; r < 40; r++) begin
      ihl  = int'($urandom_range(5, 8));
      plen = int'($urandom_range(0, 20));
      pad  = int'($urandom_range(0, 6));
      case ($urandom_range(0, 3))
        0, 1:    pr = 8'd17;
        2:       pr = 8'd6;
        default: pr = 8'd1;
      endcase
      case ($urandom_range(0, 3))
        0, 1:    dst = LOCAL_IP;
        2:       dst = 32'hFFFF_FFFF;
        default: dst = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       flags = 16'h2000;
        1:       flags = 16'(($urandom_range(1, 8191)));
        2:       flags = 16'h4000;
        default: flags = 16'h0000;
      endcase
      build(ihl, plen, pad, pr, dst, flags);
      if ($urandom_range(0, 5) == 0)
        frm[$urandom_range(0, 4 * ihl - 1)] ^= 8'(1 << $urandom_range(0, 7));
      if ($urandom_range(0, 5) == 0) begin
        cut = int'($urandom_range(1, frm.size()));
        while (frm.size() > cut) void'(frm.pop_back());
      end
      run_frame($sformatf("rand%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rx_ipv4_parser.md
# rx_ipv4_parser

Receive-side IPv4 stage that sits directly downstream of `rx_ethernet`. It consumes the IPv4 EtherType payload byte stream and validates the IPv4 header: version, IHL, header checksum, destination address, fragmentation and total length. For accepted datagrams it forwards the payload bytes, trimmed of Ethernet padding, to the UDP or TCP consumer as a strobed byte stream, along with per-datagram header metadata.

## Interface

Parameters:
- `OCT`, 8: byte width.
- `PROTO_UDP`, 8'd17: protocol number steered to `rx_data_udp`.
- `PROTO_TCP`, 8'd6: protocol number steered to `rx_data_tcp`.
- `ACCEPT_BCAST`, 1: also accept destination 255.255.255.255.

Ports:
- `RX_CLK`, in, 1: GMII receive clock. This is the only clock.
- `rst`, in, 1: reset, asynchronous, active-low.
- `ip_addr`, in, 32: local IPv4 address (CSR). Must be quasi-static.
- `rx_payload_ip`, in, 1: high while IPv4 payload bytes arrive from `rx_ethernet`.
  - One byte per cycle, contiguous.
  - Falling edge means end of frame.
  - Low for at least 1 cycle between frames.
- `rx_payload`, in, 8: payload byte, valid when `rx_payload_ip` is high.
- `rx_data`, out, 8: forwarded payload byte.
- `rx_data_udp`, out, 1: `rx_data` is a UDP datagram payload byte.
- `rx_data_tcp`, out, 1: `rx_data` is a TCP datagram payload byte.
- `rx_hdr_valid`, out, 1: 1-cycle pulse when a header is accepted.
- `rx_src_ip`, out, 32: source address. Updated with `rx_hdr_valid`, held until the next pulse.
- `rx_proto`, out, 8: protocol. Updated and held like `rx_src_ip`.
- `rx_len`, out, 16: payload length = total_length − IHL*4. Updated and held like `rx_src_ip`.
- `rx_end`, out, 1: 1-cycle pulse marking the last payload byte of an accepted datagram.
- `rx_ip_err`, out, 1: 1-cycle pulse when a datagram is rejected as malformed or truncated.

## Operation

States:
- **IDLE**: wait for `rx_payload_ip` high. Byte 0 is processed in the cycle it arrives; go to HDR.
- **HDR**: count header bytes (6-bit index k) and latch fields:
  - version/IHL at k=0
  - total_length at k=2,3
  - flags/fragment offset at k=6,7
  - protocol at k=9
  - source address at k=12..15
  - destination address at k=16..19
  - Option bytes (k=20..H−1) are checksummed but not output.
- **PAYLOAD**: forward bytes while the 16-bit payload counter is below `rx_len`. Then go to DROP.
- **DROP**: ignore input until `rx_payload_ip` is low, then go to IDLE. This is also the reset state.

Header length is H = IHL*4.

Checksum:
- 16-bit big-endian words over bytes 0..H−1; the even-indexed byte is the high byte.
- Accumulate as a 16-bit ones'-complement sum, folding the end-around carry on every add.
- The header passes iff the final sum is 16'hFFFF.

Decision at the last header byte (k=H−1):
- **Accept**: all of the following hold:
  - checksum passes
  - total_length ≥ H
  - MF=0 and fragment offset=0
  - destination equals `ip_addr` (or broadcast when `ACCEPT_BCAST`=1)
  - protocol is `PROTO_UDP` or `PROTO_TCP`
- **Error**: checksum fail, total_length < H, or a fragment. Pulse `rx_ip_err`, go to DROP.
- **Silent drop**: address mismatch or another protocol. No pulse; go to DROP.
- **Early error at k=0**: version ≠ 4 or IHL < 5. Pulse `rx_ip_err`, go to DROP.

Frame-end and zero-length cases:
- Bytes beyond total_length (Ethernet padding) are never forwarded.
- If `rx_payload_ip` falls in HDR, or in PAYLOAD before `rx_len` bytes have arrived, pulse `rx_ip_err`, go to IDLE, and do not pulse `rx_end`.
- If `rx_len` is 0, `rx_end` pulses together with `rx_hdr_valid` and no strobes follow.

Reset:
- All outputs are 0 while `rst` is low, including the held metadata registers.
- The state after reset is DROP, so a frame already in progress when reset releases is discarded.
- Assertion mid-payload aborts the datagram with no `rx_end` and no `rx_ip_err`.

## Timing

- Byte k arrives at cycle t0+k.
- `rx_hdr_valid`, metadata update, and any header-decision `rx_ip_err` occur at cycle t0+H.
- An early error (version/IHL) pulses `rx_ip_err` at t0+1.
- Payload byte j arrives at t0+H+j and is output on `rx_data` with its strobe at t0+H+j+1 (fixed 1-cycle latency).
- `rx_end` coincides with the strobe of byte `rx_len`−1.
- A truncation `rx_ip_err` occurs in the cycle after `rx_payload_ip` falls.
- At most one of `rx_data_udp` and `rx_data_tcp` is high in any cycle.
- Strobes are contiguous within a datagram, with no bubbles.

## Test plan

1. **UDP accept.** IHL=5, total_length=36, proto 17, dst=`ip_addr`=192.168.1.10, valid checksum, followed by 10 padding bytes.
   - `rx_hdr_valid` at t0+20 with `rx_len`=16 and `rx_proto`=17.
   - 16 `rx_data_udp` strobes matching the input bytes.
   - `rx_end` on the 16th strobe; no strobes during padding.
2. **Bad checksum.** The same packet with one header bit flipped.
   - `rx_ip_err` at t0+20.
   - No `rx_hdr_valid`, no strobes.
3. **TCP with options.** IHL=6 (4 option bytes included in the checksum), total_length=32.
   - `rx_hdr_valid` at t0+24, `rx_len`=8.
   - 8 `rx_data_tcp` strobes; option bytes are not output.
4. **Address filter.** Send dst=192.168.1.11, then the same packet with dst=255.255.255.255.
   - First packet: no outputs at all.
   - Second packet: accepted like scenario 1.
5. **Truncation and fragments.**
   - Drop `rx_payload_ip` after 10 of 16 payload bytes: expect 10 strobes, `rx_ip_err` one cycle after the fall, no `rx_end`.
   - Send a packet with MF=1: expect `rx_ip_err` at t0+20.
   - Send a packet with version=6: expect `rx_ip_err` at t0+1.
6. **Reset mid-payload.** Assert `rst` low at payload byte 5, release while `rx_payload_ip` is still high.
   - All outputs are 0 and the rest of that frame is ignored.
   - The next frame is parsed exactly as in scenario 1.
